// File: rtl/iotdf_stream_tx.sv
// iotdf_stream_tx: serializes 128-bit words LSB-first into bytes for the IoT data filter,
// holding one function code per round of ROUND_WORDS words.
module iotdf_stream_tx #(
  parameter int ROUND_WORDS = 8,
  parameter int GAP_CYCLES  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [127:0] word_data,
  input  logic [2:0]   word_fn,
  input  logic         busy,
  output logic         in_en,
  output logic [7:0]   iot_in,
  output logic [2:0]   fn_sel,
  output logic         round_done
);
  localparam int WCW = ROUND_WORDS > 1 ? $clog2(ROUND_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(ROUND_WORDS - 1);
  localparam logic [3:0] LAST_G = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [127:0] sr_q, sr_d, hr_q, hr_d;
  logic [2:0] sr_fn_q, sr_fn_d, hr_fn_q, hr_fn_d, fn_sel_q, fn_sel_d;
  logic hr_full_q, hr_full_d, hr_first_q, hr_first_d, fn_pend_q, fn_pend_d;
  logic [3:0] byte_cnt_q, byte_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d, acc_cnt_q, acc_cnt_d;
  logic in_en_q, in_en_d, word_ready_q, word_ready_d;
  logic round_done_q, round_done_d, done_pend_q, done_pend_d;
  logic [7:0] iot_in_q, iot_in_d;
  logic acc, move, round_end;
  assign acc = word_valid && word_ready_q;
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    sr_fn_d      = sr_fn_q;
    hr_d         = hr_q;
    hr_fn_d      = hr_fn_q;
    hr_first_d   = hr_first_q;
    fn_sel_d     = fn_sel_q;
    fn_pend_d    = fn_pend_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    word_cnt_d   = word_cnt_q;
    acc_cnt_d    = acc_cnt_q;
    iot_in_d     = iot_in_q;
    in_en_d      = 1'b0;
    round_done_d = done_pend_q;
    done_pend_d  = 1'b0;
    move         = 1'b0;
    round_end    = 1'b0;
    case (state_q)
      IDLE: move = hr_full_q;
      SEND: if (!busy) begin
        in_en_d    = 1'b1;
        iot_in_d   = sr_q[{byte_cnt_q, 3'b000} +: 8];
        byte_cnt_d = byte_cnt_q + 4'd1;
        // a round's fn code reloaded mid-stream is held back until its first byte goes out
        fn_sel_d   = (byte_cnt_q == 4'd0 && fn_pend_q) ? sr_fn_q : fn_sel_q;
        fn_pend_d  = fn_pend_q && byte_cnt_q != 4'd0;
        if (byte_cnt_q == 4'hf) begin
          round_end   = word_cnt_q == LAST_W;
          word_cnt_d  = round_end ? '0 : word_cnt_q + 1'b1;
          done_pend_d = round_end;
          if (round_end && GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else if (hr_full_q) move = 1'b1;
          else state_d = IDLE;
        end
      end
      GAP: if (gap_cnt_q == LAST_G) begin
        move    = hr_full_q;
        state_d = IDLE;
      end else gap_cnt_d = gap_cnt_q + 4'd1;
      default: state_d = IDLE;
    endcase
    if (move) begin
      state_d    = SEND;
      sr_d       = hr_q;
      sr_fn_d    = hr_fn_q;
      byte_cnt_d = '0;
      fn_pend_d  = hr_first_q && state_q == SEND;
      fn_sel_d   = (hr_first_q && state_q != SEND) ? hr_fn_q : fn_sel_d;
    end
    if (acc) begin
      hr_d       = word_data;
      hr_first_d = acc_cnt_q == '0;
      hr_fn_d    = acc_cnt_q == '0 ? word_fn : hr_fn_q;
      acc_cnt_d  = acc_cnt_q == LAST_W ? '0 : acc_cnt_q + 1'b1;
    end
    hr_full_d    = acc || (hr_full_q && !move);
    word_ready_d = !hr_full_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      sr_fn_q      <= '0;
      hr_q         <= '0;
      hr_fn_q      <= '0;
      hr_first_q   <= 1'b0;
      hr_full_q    <= 1'b0;
      fn_sel_q     <= '0;
      fn_pend_q    <= 1'b0;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      word_cnt_q   <= '0;
      acc_cnt_q    <= '0;
      iot_in_q     <= '0;
      in_en_q      <= 1'b0;
      word_ready_q <= 1'b0;
      round_done_q <= 1'b0;
      done_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      sr_fn_q      <= sr_fn_d;
      hr_q         <= hr_d;
      hr_fn_q      <= hr_fn_d;
      hr_first_q   <= hr_first_d;
      hr_full_q    <= hr_full_d;
      fn_sel_q     <= fn_sel_d;
      fn_pend_q    <= fn_pend_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      word_cnt_q   <= word_cnt_d;
      acc_cnt_q    <= acc_cnt_d;
      iot_in_q     <= iot_in_d;
      in_en_q      <= in_en_d;
      word_ready_q <= word_ready_d;
      round_done_q <= round_done_d;
      done_pend_q  <= done_pend_d;
    end
  end
  assign in_en      = in_en_q;
  assign iot_in     = iot_in_q;
  assign fn_sel     = fn_sel_q;
  assign round_done = round_done_q;
  assign word_ready = word_ready_q;
endmodule
